decode_flow_ctrl: RTL and testbench

Sequencing controller for the decode stage of the out-of-order core. Decides each cycle how many lanes move from the fetch→decode FIFO into the decode→rename FIFO, generates the pop/push masks and strobes, sequences the decode→rename flush and post-flush recovery on a commit flush, and produces the idle feedback and full-stall event for the CSR file. The decode datapath consumes its masks as lane enables.

---
 rtl/decode_flow_ctrl_pkg.sv | 19 +
 rtl/decode_flow_ctrl_if.sv | 36 +++
 rtl/decode_lane_grant.sv | 42 ++++
 rtl/decode_flow_ctrl.sv | 107 ++++++++++
 tb/tb_decode_flow_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/decode_flow_ctrl_pkg.sv
// Shared definitions for the decode-stage flow controller: lane count,
// sequencing states and the stall-counter helper.
package decode_flow_ctrl_pkg;

    localparam int DECODE_WIDTH = 4;
    localparam int STALL_W      = 32;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        RECOVER = 2'd2
    } decode_flow_ctrl_state_t;

    // Saturating increment: the CSR event counter must never wrap to zero.
    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] value);
        return (value == '1) ? value : value + STALL_W'(1);
    endfunction

endpackage

// File: rtl/decode_flow_ctrl_if.sv
// Fetch->decode pop side and decode->rename push side of the decode stage,
// bundled so the controller and the FIFOs share one port list.
interface decode_flow_ctrl_if
    import decode_flow_ctrl_pkg::*;
#(
    parameter int WIDTH  = DECODE_WIDTH,
    parameter int FREE_W = 4
);

    logic [WIDTH-1:0]  fd_valid;
    logic [FREE_W-1:0] dr_free_count;
    logic [WIDTH-1:0]  fd_pop_valid;
    logic              fd_pop;
    logic [WIDTH-1:0]  dr_push_valid;
    logic              dr_push;

    // The FIFO side drives lane status and consumes the masks.
    modport master (
        output fd_valid,
        output dr_free_count,
        input  fd_pop_valid,
        input  fd_pop,
        input  dr_push_valid,
        input  dr_push
    );

    modport slave (
        input  fd_valid,
        input  dr_free_count,
        output fd_pop_valid,
        output fd_pop,
        output dr_push_valid,
        output dr_push
    );

endinterface

// File: rtl/decode_lane_grant.sv
// Grants the longest in-order run of valid lanes that fits in the downstream
// FIFO; purely combinational so it can sit in front of any lane handshake.
module decode_lane_grant #(
    parameter int WIDTH  = 4,
    parameter int FREE_W = 4
) (
    input  logic              enable,
    input  logic [WIDTH-1:0]  valid,
    input  logic [FREE_W-1:0] free_count,
    output logic [WIDTH-1:0]  grant_mask,
    output logic              full_add
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int CMP_W = (CNT_W > FREE_W) ? CNT_W : FREE_W;

    logic [CMP_W-1:0] n_avail;
    logic [CMP_W-1:0] free_ext;
    logic             prefix_ok;

    assign free_ext = CMP_W'(free_count);

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred. Blocking '=' is correct in
    // combinational logic: later loop iterations must see the updated prefix.
    always_comb begin
        n_avail    = '0;
        grant_mask = '0;
        prefix_ok  = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            prefix_ok = prefix_ok & valid[i];
            if (prefix_ok) begin
                n_avail       = n_avail + CMP_W'(1);
                grant_mask[i] = enable && (CMP_W'(i) < free_ext);
            end
        end
    end

    // Back-pressure event: some in-order lane was ready but had no slot.
    assign full_add = enable && (n_avail > free_ext);

endmodule

// File: rtl/decode_flow_ctrl.sv
// Decode-stage sequencer: lane grant, decode->rename flush and post-flush
// recovery, idle feedback and the saturating full-stall counter.
module decode_flow_ctrl
    import decode_flow_ctrl_pkg::*;
#(
    parameter int WIDTH          = DECODE_WIDTH,
    parameter int FREE_W         = 4,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_flow_ctrl_if.slave    fd_dr,
    input  logic                 commit_flush,
    input  logic                 stall_count_clear,
    output logic                 dr_flush,
    output logic                 idle,
    output logic                 full_add,
    output logic [STALL_W-1:0]   stall_count
);

    localparam int RC_W = $clog2(RECOVER_CYCLES + 1);

    localparam logic [1:0] S_RUN     = RUN;
    localparam logic [1:0] S_FLUSH   = FLUSH;
    localparam logic [1:0] S_RECOVER = RECOVER;

    logic [1:0]         state_q, state_d;
    logic [RC_W-1:0]    rc_q, rc_d;
    logic               dr_flush_q;
    logic [STALL_W-1:0] stall_q;
    logic               run_en;
    logic [WIDTH-1:0]   grant_mask;

    // A flush seen this cycle kills the grant: the lanes it would move are
    // younger than the flushing instruction.
    assign run_en = rst && (state_q == S_RUN) && !commit_flush;

    decode_lane_grant #(
        .WIDTH  (WIDTH),
        .FREE_W (FREE_W)
    ) u_lane_grant (
        .enable     (run_en),
        .valid      (fd_dr.fd_valid),
        .free_count (fd_dr.dr_free_count),
        .grant_mask (grant_mask),
        .full_add   (full_add)
    );

    assign fd_dr.fd_pop_valid  = grant_mask;
    assign fd_dr.dr_push_valid = grant_mask;
    assign fd_dr.fd_pop        = |grant_mask;
    assign fd_dr.dr_push       = |grant_mask;

    assign idle        = rst && (state_q == S_RUN) && (fd_dr.fd_valid == '0);
    assign dr_flush    = dr_flush_q;
    assign stall_count = stall_q;

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        case (state_q)
            S_RUN: begin
                state_d = S_RUN;
            end
            S_FLUSH: begin
                state_d = S_RECOVER;
                rc_d    = RC_W'(RECOVER_CYCLES);
            end
            S_RECOVER: begin
                rc_d = rc_q - RC_W'(1);
                if (rc_q == RC_W'(1)) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
                rc_d    = '0;
            end
        endcase
        // A new flush restarts the whole sequence from any state.
        if (commit_flush) begin
            state_d = S_FLUSH;
            rc_d    = '0;
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_RUN;
            rc_q       <= '0;
            dr_flush_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            rc_q       <= rc_d;
            dr_flush_q <= commit_flush;
            if (stall_count_clear) begin
                stall_q <= '0;
            end else if (full_add) begin
                stall_q <= sat_inc(stall_q);
            end
        end
    end

endmodule

// File: tb/tb_decode_flow_ctrl.sv
// Directed bench for decode_flow_ctrl: a driver applies one vector per cycle
// and queues its hand-computed response; a monitor pops and compares.
module tb_decode_flow_ctrl;

    logic        clk;
    logic        rst;
    logic        commit_flush;
    logic        stall_count_clear;
    logic        dr_flush;
    logic        idle;
    logic        full_add;
    logic [31:0] stall_count;

    decode_flow_ctrl_if #(.WIDTH(4), .FREE_W(4)) bus ();

    decode_flow_ctrl #(
        .WIDTH          (4),
        .FREE_W         (4),
        .RECOVER_CYCLES (1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .fd_dr             (bus.slave),
        .commit_flush      (commit_flush),
        .stall_count_clear (stall_count_clear),
        .dr_flush          (dr_flush),
        .idle              (idle),
        .full_add          (full_add),
        .stall_count       (stall_count)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  free;
        logic        cf;
        logic        clr;
        logic        pre;
        logic [3:0]  mask;
        logic        fl;
        logic        idl;
        logic        full;
        logic [31:0] stall;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    vec_t got;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic preload_on = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic add(input string n, input logic r, input logic [3:0] v, input logic [3:0] f,
                       input logic cf, input logic clr, input logic pre, input logic [3:0] m,
                       input logic fl, input logic idl, input logic full, input logic [31:0] st);
        vec_t x;
        x.name = n; x.rst = r; x.valid = v; x.free = f; x.cf = cf; x.clr = clr; x.pre = pre;
        x.mask = m; x.fl = fl; x.idl = idl; x.full = full; x.stall = st;
        vecs.push_back(x);
    endtask

    // Monitor: outputs are combinational, so each cycle is sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                got = exp_q.pop_front();
                check({got.name, "/fd_pop_valid"},  32'(bus.fd_pop_valid),  32'(got.mask));
                check({got.name, "/dr_push_valid"}, 32'(bus.dr_push_valid), 32'(got.mask));
                check({got.name, "/fd_pop"},        32'(bus.fd_pop),        32'(|got.mask));
                check({got.name, "/dr_push"},       32'(bus.dr_push),       32'(|got.mask));
                check({got.name, "/dr_flush"},      32'(dr_flush),          32'(got.fl));
                check({got.name, "/idle"},          32'(idle),              32'(got.idl));
                check({got.name, "/full_add"},      32'(full_add),          32'(got.full));
                check({got.name, "/stall_count"},   stall_count,            got.stall);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b0;
        commit_flush      = 1'b0;
        stall_count_clear = 1'b0;
        bus.fd_valid      = 4'b0000;
        bus.dr_free_count = 4'd0;

        //   name              rst valid    free cf clr pre mask     fl idl full stall
        add("reset",           0, 4'b1111, 4'd8, 0, 0, 0, 4'b0000, 0, 0, 0, 32'd0);
        add("full_grant",      1, 4'b1111, 4'd8, 0, 0, 0, 4'b1111, 0, 0, 0, 32'd0);
        add("partial",         1, 4'b0111, 4'd2, 0, 0, 0, 4'b0011, 0, 0, 1, 32'd0);
        add("empty_idle",      1, 4'b0000, 4'd8, 0, 0, 0, 4'b0000, 0, 1, 0, 32'd1);
        add("noncontig",       1, 4'b1101, 4'd8, 0, 0, 0, 4'b0001, 0, 0, 0, 32'd1);
        add("zero_free",       1, 4'b1111, 4'd0, 0, 0, 0, 4'b0000, 0, 0, 1, 32'd1);
        add("empty_nofree",    1, 4'b0000, 4'd0, 0, 0, 0, 4'b0000, 0, 1, 0, 32'd2);
        add("clear",           1, 4'b0011, 4'd15,0, 1, 0, 4'b0011, 0, 0, 0, 32'd2);
        add("clear_vs_full",   1, 4'b1111, 4'd3, 0, 1, 0, 4'b0111, 0, 0, 1, 32'd0);
        add("clear_won",       1, 4'b0001, 4'd1, 0, 0, 0, 4'b0001, 0, 0, 0, 32'd0);
        add("flush_req",       1, 4'b1111, 4'd8, 1, 0, 0, 4'b0000, 0, 0, 0, 32'd0);
        add("flush",           1, 4'b1111, 4'd8, 0, 0, 0, 4'b0000, 1, 0, 0, 32'd0);
        add("recover",         1, 4'b1111, 4'd8, 0, 0, 0, 4'b0000, 0, 0, 0, 32'd0);
        add("resume",          1, 4'b1111, 4'd8, 0, 0, 0, 4'b1111, 0, 0, 0, 32'd0);
        add("flush2_req",      1, 4'b1111, 4'd8, 1, 0, 0, 4'b0000, 0, 0, 0, 32'd0);
        add("flush2",          1, 4'b1111, 4'd8, 0, 0, 0, 4'b0000, 1, 0, 0, 32'd0);
        add("recover_reflush", 1, 4'b1111, 4'd8, 1, 0, 0, 4'b0000, 0, 0, 0, 32'd0);
        add("reflush",         1, 4'b1111, 4'd8, 0, 0, 0, 4'b0000, 1, 0, 0, 32'd0);
        add("recover2",        1, 4'b1111, 4'd8, 0, 0, 0, 4'b0000, 0, 0, 0, 32'd0);
        add("resume2",         1, 4'b0111, 4'd8, 0, 0, 0, 4'b0111, 0, 0, 0, 32'd0);
        add("flush3_req",      1, 4'b0111, 4'd8, 1, 0, 0, 4'b0000, 0, 0, 0, 32'd0);
        add("flush3_in_flush", 1, 4'b1111, 4'd8, 1, 0, 0, 4'b0000, 1, 0, 0, 32'd0);
        add("flush3_again",    1, 4'b1111, 4'd8, 0, 0, 0, 4'b0000, 1, 0, 0, 32'd0);
        add("recover3",        1, 4'b1111, 4'd8, 0, 0, 0, 4'b0000, 0, 0, 0, 32'd0);
        add("resume3",         1, 4'b1111, 4'd8, 0, 0, 0, 4'b1111, 0, 0, 0, 32'd0);
        add("preload",         1, 4'b0000, 4'd8, 0, 0, 1, 4'b0000, 0, 1, 0, 32'hFFFF_FFFE);
        add("sat_stall1",      1, 4'b1111, 4'd1, 0, 0, 0, 4'b0001, 0, 0, 1, 32'hFFFF_FFFE);
        add("sat_stall2",      1, 4'b1111, 4'd1, 0, 0, 0, 4'b0001, 0, 0, 1, 32'hFFFF_FFFF);
        add("sat_stall3",      1, 4'b1111, 4'd1, 0, 0, 0, 4'b0001, 0, 0, 1, 32'hFFFF_FFFF);
        add("sat_hold",        1, 4'b0000, 4'd8, 0, 0, 0, 4'b0000, 0, 1, 0, 32'hFFFF_FFFF);
        add("rst_flush_req",   1, 4'b1111, 4'd8, 1, 0, 0, 4'b0000, 0, 0, 0, 32'hFFFF_FFFF);
        add("rst_mid_flush",   0, 4'b1111, 4'd8, 0, 0, 0, 4'b0000, 0, 0, 0, 32'd0);
        add("after_rst",       1, 4'b1111, 4'd8, 0, 0, 0, 4'b1111, 0, 0, 0, 32'd0);
        add("no_late_flush",   1, 4'b0000, 4'd8, 0, 0, 0, 4'b0000, 0, 1, 0, 32'd0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            if (preload_on) begin
                release dut.stall_q;
                preload_on = 1'b0;
            end
            rst               = vecs[i].rst;
            bus.fd_valid      = vecs[i].valid;
            bus.dr_free_count = vecs[i].free;
            commit_flush      = vecs[i].cf;
            stall_count_clear = vecs[i].clr;
            exp_q.push_back(vecs[i]);
            // Jump the counter near saturation; held across one non-stall edge.
            if (vecs[i].pre) begin
                force dut.stall_q = 32'hFFFF_FFFE;
                preload_on = 1'b1;
            end
        end

        for (int k = 0; k < 20; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        check("drain/pending_vectors", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
